// File: rtl/seq_divider.sv
// Unsigned restoring shift-subtract divider: latches operands on Start,
// retires one quotient bit per clock, then holds Quotient/Remainder until the next Start.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             Div_By_Zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH:0]   r_r;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic             w_accept;
  logic             w_last;
  logic             w_div_zero;
  logic [WIDTH:0]   w_r_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_fits;
  logic [WIDTH:0]   w_r_next;
  logic [WIDTH-1:0] w_q_next;

  assign w_accept   = (r_state == S_IDLE) && Start;
  assign w_last     = (r_state == S_RUN) && (r_cnt == LAST_STEP);
  assign w_div_zero = (Divisor == '0);

  // One restoring step: shift {R,Q} left, try subtracting D, keep the result only if non-negative.
  assign w_r_shift = {r_r[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_trial   = w_r_shift - {1'b0, r_d};
  assign w_fits    = ~w_trial[WIDTH];
  assign w_r_next  = w_fits ? w_trial : w_r_shift;
  assign w_q_next  = {r_q[WIDTH-2:0], w_fits};

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: default assigned first so no path leaves w_state_next unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (Start) begin
          w_state_next = w_div_zero ? S_HOLD : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!Start) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_r         <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else if (w_accept) begin
      r_d   <= Divisor;
      r_q   <= Dividend;
      r_r   <= '0;
      r_cnt <= '0;
      r_dbz <= w_div_zero;
      if (w_div_zero) begin
        r_quotient  <= '1;
        r_remainder <= Dividend;
      end
    end else if (r_state == S_RUN) begin
      r_r   <= w_r_next;
      r_q   <= w_q_next;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_quotient  <= w_q_next;
        r_remainder <= w_r_next[WIDTH-1:0];
      end
    end
  end

  assign Quotient    = r_quotient;
  assign Remainder   = r_remainder;
  assign Busy        = (r_state == S_RUN);
  assign Done        = (r_state == S_HOLD);
  assign Div_By_Zero = r_dbz;

endmodule
